// File: rtl/mem_stage_mc.sv
`default_nettype none
// mem_stage_mc: E->M pipeline register plus byte-addressable data memory with
// programmable wait states, byte/half/word sizing, sign/zero extension and misalign detection.
module mem_stage_mc #(
    parameter int DEPTH_WORDS = 64,
    parameter int MEM_LATENCY = 0
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        FlushM,
    input  logic        RegWriteE,
    input  logic        MemtoRegE,
    input  logic        MemWriteE,
    input  logic [1:0]  MemSizeE,
    input  logic        MemSignedE,
    input  logic [31:0] ALUOutE,
    input  logic [31:0] WriteDataE,
    input  logic [4:0]  WriteRegE,
    output logic        RegWriteM,
    output logic        MemtoRegM,
    output logic [31:0] ALUOutM,
    output logic [4:0]  WriteRegM,
    output logic [31:0] RD,
    output logic        MemBusyM,
    output logic        MisalignM
);
    localparam int AW = $clog2(DEPTH_WORDS);

    logic        regwrite_q, memtoreg_q, memwrite_q, signed_q;
    logic [1:0]  size_q;
    logic [31:0] alu_q, wdata_q;
    logic [4:0]  wreg_q;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] mem_q [DEPTH_WORDS];

    logic          mem_op, is_word, is_half, misaligned, wait_left, busy, we;
    logic [3:0]    be;
    logic [31:0]   wlane, rword;
    logic [15:0]   rhalf;
    logic [7:0]    rbyte;
    logic [AW-1:0] idx;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            regwrite_q <= 1'b0;
            memtoreg_q <= 1'b0;
            memwrite_q <= 1'b0;
            size_q     <= 2'b00;
            signed_q   <= 1'b0;
            alu_q      <= '0;
            wdata_q    <= '0;
            wreg_q     <= '0;
            cnt_q      <= '0;
        end else begin
            cnt_q <= cnt_d;
            // While busy every field holds, so a concurrent flush is dropped.
            if (!busy) begin
                if (FlushM) begin
                    regwrite_q <= 1'b0;
                    memtoreg_q <= 1'b0;
                    memwrite_q <= 1'b0;
                    size_q     <= 2'b00;
                    signed_q   <= 1'b0;
                    alu_q      <= '0;
                    wdata_q    <= '0;
                    wreg_q     <= '0;
                end else begin
                    regwrite_q <= RegWriteE;
                    memtoreg_q <= MemtoRegE;
                    memwrite_q <= MemWriteE;
                    size_q     <= MemSizeE;
                    signed_q   <= MemSignedE;
                    alu_q      <= ALUOutE;
                    wdata_q    <= WriteDataE;
                    wreg_q     <= WriteRegE;
                end
            end
        end
    end

    always_comb cnt_d = busy ? cnt_q + 3'd1 : 3'd0;

    generate
        if (MEM_LATENCY == 0) begin : g_no_wait
            assign wait_left = 1'b0;
        end else begin : g_wait
            localparam logic [2:0] LAT = 3'(MEM_LATENCY);
            assign wait_left = (cnt_q < LAT);
        end
    endgenerate

    assign mem_op     = memtoreg_q | memwrite_q;
    assign is_word    = size_q[1];
    assign is_half    = (size_q == 2'b01);
    assign misaligned = is_word ? (alu_q[1:0] != 2'b00) : (is_half & alu_q[0]);
    assign MisalignM  = mem_op & misaligned;
    assign busy       = mem_op & ~MisalignM & wait_left;
    assign we         = memwrite_q & ~MisalignM & ~busy;
    assign idx        = alu_q[AW+1:2];

    always_comb begin
        if (is_word) begin
            be    = 4'b1111;
            wlane = wdata_q;
        end else if (is_half) begin
            be    = alu_q[1] ? 4'b1100 : 4'b0011;
            wlane = {2{wdata_q[15:0]}};
        end else begin
            be    = 4'b0001 << alu_q[1:0];
            wlane = {4{wdata_q[7:0]}};
        end
    end

    // Storage carries no reset; a store commits on the edge that ends its access.
    always_ff @(posedge CLK) begin
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem_q[idx][8*b +: 8] <= wlane[8*b +: 8];
            end
        end
    end

    assign rword = mem_q[idx];
    assign rhalf = alu_q[1] ? rword[31:16] : rword[15:0];
    assign rbyte = alu_q[0] ? rhalf[15:8] : rhalf[7:0];

    always_comb begin
        RD = '0;
        if (memtoreg_q && !busy && !MisalignM) begin
            if (is_word)      RD = rword;
            else if (is_half) RD = {{16{signed_q & rhalf[15]}}, rhalf};
            else              RD = {{24{signed_q & rbyte[7]}}, rbyte};
        end
    end

    assign MemBusyM  = busy;
    assign RegWriteM = regwrite_q & ~busy;
    assign MemtoRegM = memtoreg_q;
    assign ALUOutM   = alu_q;
    assign WriteRegM = wreg_q;
endmodule
`default_nettype wire
